// File: rtl/spi_accel_responder.sv
// spi_accel_responder
//   SPI mode-3 responder that looks like a 3-axis accelerometer register map:
//   a 64 x 8 register file. 0x00 reads as Device_ID. 0x31 is DATA_FORMAT.
//   0x32..0x37 hold an X/Y/Z snapshot that is taken when a transaction starts.
//
// Ports
//   Clk, nReset          system clock (rising edge), async active-low reset
//   X, Y, Z              fabric samples served as 0x32..0x37 (LSB first)
//   nCS, SClk, SDI       SPI inputs, asynchronous to Clk
//   SDO                  SPI output, updated on synchronised SClk falling edges
//   Wr_Valid             one-Clk pulse per accepted register write
//   Wr_Address, Wr_Data  address and data of that write
//   Data_Format          live copy of register 0x31
module spi_accel_responder #(
    parameter logic [7:0] Device_ID    = 8'hE5,
    parameter logic [7:0] Format_Reset = 8'h00
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic [15:0] Z,
    input  logic        nCS,
    input  logic        SClk,
    input  logic        SDI,
    output logic        SDO,
    output logic        Wr_Valid,
    output logic [5:0]  Wr_Address,
    output logic [7:0]  Wr_Data,
    output logic [7:0]  Data_Format
);

    localparam logic [5:0] ADDR_FMT = 6'h31;

    typedef enum logic [1:0] {S_IDLE, S_COMMAND, S_DATA} state_e;

    state_e      state_q, state_d;

    // Synchronisers: [1] is the synchronised value, [2] its previous copy.
    logic [2:0]  ncs_q;
    logic [2:0]  sclk_q;
    logic [1:0]  sdi_q;

    logic [7:0]  regs_q [64];
    logic [7:0]  rx_q;
    logic [7:0]  tx_q;
    logic [2:0]  bit_cnt_q;
    logic [5:0]  addr_q;
    logic        mb_q;
    logic        rnw_q;

    logic        ncs_fall, ncs_rise, sclk_rise, sclk_fall, sdi_s;
    logic        snap_en, cmd_done, data_done, shift_en, drive_en, sdo_idle;
    logic [7:0]  rx_byte;
    logic [5:0]  addr_next, rd_addr;
    logic [7:0]  rd_val;
    logic        wr_ok, load_rd;

    // nCS synchroniser resets low so that a reset released in the middle of a
    // transaction (nCS still low) does not look like a new falling edge; the
    // next real falling edge starts fresh.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            ncs_q  <= '0;
            sclk_q <= '1;
            sdi_q  <= '0;
        end else begin
            ncs_q  <= {ncs_q[1:0], nCS};
            sclk_q <= {sclk_q[1:0], SClk};
            sdi_q  <= {sdi_q[0], SDI};
        end
    end

    assign ncs_fall  = ~ncs_q[1] &  ncs_q[2];
    assign ncs_rise  =  ncs_q[1] & ~ncs_q[2];
    // SClk edges only count while the synchronised nCS is low.
    assign sclk_rise = ~ncs_q[1] &  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~ncs_q[1] & ~sclk_q[1] &  sclk_q[2];
    assign sdi_s     = sdi_q[1];

    // FSM: state register
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (ncs_rise) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (ncs_fall) state_d = S_COMMAND;
                S_COMMAND: if (sclk_rise && bit_cnt_q == 3'd7) state_d = S_DATA;
                S_DATA:    state_d = S_DATA;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // FSM: control strobes
    always_comb begin
        snap_en   = (state_q == S_IDLE) && ncs_fall;
        shift_en  = (state_q != S_IDLE) && sclk_rise;
        cmd_done  = (state_q == S_COMMAND) && sclk_rise && (bit_cnt_q == 3'd7);
        data_done = (state_q == S_DATA) && sclk_rise && (bit_cnt_q == 3'd7);
        drive_en  = (state_q == S_DATA) && sclk_fall;
        sdo_idle  = (state_q != S_DATA) || ncs_rise;
    end

    // Datapath decode
    always_comb begin
        rx_byte   = {rx_q[6:0], sdi_s};
        addr_next = mb_q ? addr_q + 6'd1 : addr_q;   // 6-bit add wraps 0x3F -> 0x00
        rd_addr   = cmd_done ? rx_byte[5:0] : addr_next;
        rd_val    = (rd_addr == '0) ? Device_ID : regs_q[rd_addr];
        wr_ok     = (addr_q != '0) && !((addr_q >= 6'h32) && (addr_q <= 6'h37));
        load_rd   = cmd_done ? rx_byte[7] : rnw_q;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int unsigned i = 0; i < 64; i++) begin
                regs_q[i[5:0]] <= '0;
            end
            regs_q[ADDR_FMT] <= Format_Reset;
            rx_q       <= '0;
            tx_q       <= '1;
            bit_cnt_q  <= '0;
            addr_q     <= '0;
            mb_q       <= 1'b0;
            rnw_q      <= 1'b0;
            SDO        <= 1'b1;
            Wr_Valid   <= 1'b0;
            Wr_Address <= '0;
            Wr_Data    <= '0;
        end else begin
            Wr_Valid <= 1'b0;

            if (snap_en) begin
                regs_q[6'h32] <= X[7:0];
                regs_q[6'h33] <= X[15:8];
                regs_q[6'h34] <= Y[7:0];
                regs_q[6'h35] <= Y[15:8];
                regs_q[6'h36] <= Z[7:0];
                regs_q[6'h37] <= Z[15:8];
                bit_cnt_q     <= '0;
            end

            if (shift_en) begin
                rx_q      <= rx_byte;
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            if (cmd_done) begin
                rnw_q  <= rx_byte[7];
                mb_q   <= rx_byte[6];
                addr_q <= rx_byte[5:0];
            end

            if (data_done) begin
                if (!rnw_q && wr_ok) begin
                    regs_q[addr_q] <= rx_byte;
                    Wr_Valid       <= 1'b1;
                    Wr_Address     <= addr_q;
                    Wr_Data        <= rx_byte;
                end
                addr_q <= addr_next;
            end

            // Byte boundary reloads the transmit byte; write transactions shift out ones.
            if (cmd_done || data_done) begin
                tx_q <= load_rd ? rd_val : '1;
            end else if (drive_en) begin
                tx_q <= {tx_q[6:0], 1'b1};
            end

            if (sdo_idle) begin
                SDO <= 1'b1;
            end else if (drive_en) begin
                SDO <= tx_q[7];
            end
        end
    end

    assign Data_Format = regs_q[ADDR_FMT];

endmodule

// File: tb/tb_spi_accel_responder.sv
// Testbench for spi_accel_responder: an SPI mode-3 initiator drives the DUT,
// a reference register map predicts read bytes and accepted writes, and two
// monitors (SDO bytes on the bus, Wr_Valid pulses) compare against queues.
module tb_spi_accel_responder;

    localparam logic [7:0] DEV_ID  = 8'hE5;
    localparam logic [7:0] FMT_RST = 8'h00;
    localparam int         HP      = 5;      // SClk half-period in Clk cycles

    logic        Clk    = 1'b0;
    logic        nReset = 1'b0;
    logic [15:0] X = '0, Y = '0, Z = '0;
    logic        nCS  = 1'b1;
    logic        SClk = 1'b1;
    logic        SDI  = 1'b0;
    logic        SDO, Wr_Valid;
    logic [5:0]  Wr_Address;
    logic [7:0]  Wr_Data, Data_Format;

    always #5 Clk = ~Clk;

    spi_accel_responder #(
        .Device_ID   (DEV_ID),
        .Format_Reset(FMT_RST)
    ) dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .X          (X),
        .Y          (Y),
        .Z          (Z),
        .nCS        (nCS),
        .SClk       (SClk),
        .SDI        (SDI),
        .SDO        (SDO),
        .Wr_Valid   (Wr_Valid),
        .Wr_Address (Wr_Address),
        .Wr_Data    (Wr_Data),
        .Data_Format(Data_Format)
    );

    typedef struct {
        logic [5:0] a;
        logic [7:0] d;
    } wr_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] pay[$];
    logic [7:0] mregs [64];
    logic [47:0] snap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < 64; i++) mregs[i] = 8'h00;
        mregs[6'h31] = FMT_RST;
    endfunction

    function automatic bit read_only(input logic [5:0] a);
        return (a == 6'h00) || (a >= 6'h32 && a <= 6'h37);
    endfunction

    function automatic logic [7:0] model_rd(input logic [5:0] a);
        int idx;
        if (a == 6'h00) return DEV_ID;
        if (a >= 6'h32 && a <= 6'h37) begin
            idx = int'(a) - 'h32;
            return snap[8*idx +: 8];
        end
        return mregs[a];
    endfunction

    // Predict the whole transaction for command byte cmd and payload pay.
    task automatic plan(input logic [7:0] cmd);
        bit         rnw = cmd[7];
        bit         mb  = cmd[6];
        int         a   = int'(cmd[5:0]);
        wr_t        w;
        foreach (pay[i]) begin
            if (rnw) begin
                exp_rd.push_back(model_rd(a[5:0]));
            end else if (!read_only(a[5:0])) begin
                mregs[a] = pay[i];
                w.a = a[5:0];
                w.d = pay[i];
                exp_wr.push_back(w);
            end
            if (mb) a = (a + 1) % 64;
        end
    endtask

    // ---------------- SPI initiator ----------------
    task automatic cs_low();
        @(negedge Clk);
        nCS  = 1'b0;
        snap = {Z, Y, X};
        repeat (6) @(negedge Clk);
    endtask

    task automatic cs_high();
        repeat (HP) @(negedge Clk);
        nCS = 1'b1;
        SDI = 1'b0;
        repeat (10) @(negedge Clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nb);
        for (int i = 0; i < nb; i++) begin
            SClk = 1'b0;
            SDI  = b[7-i];
            repeat (HP) @(negedge Clk);
            SClk = 1'b1;
            repeat (HP) @(negedge Clk);
        end
    endtask

    task automatic run_txn(input logic [7:0] cmd);
        cs_low();
        plan(cmd);
        send_bits(cmd, 8);
        foreach (pay[i]) send_bits(pay[i], 8);
        cs_high();
        chk("data_format", {24'h0, Data_Format}, {24'h0, mregs[6'h31]});
    endtask

    // ---------------- monitors ----------------
    logic [7:0] m_sdo, m_sdi;
    int         m_bits = 0;
    int         m_byte = 0;
    bit         m_rnw  = 1'b0;
    bit         m_skip = 1'b0;
    logic [7:0] m_exp;

    // Bus monitor: initiator-side view of SDO, sampled on SClk rising edges.
    always @(posedge SClk or posedge nCS or negedge nReset) begin
        if (!nReset) begin
            if (!nCS) m_skip = 1'b1;          // rest of this transaction is lost
        end else if (nCS) begin
            m_bits = 0;
            m_byte = 0;
            m_skip = 1'b0;
        end else begin
            m_sdo = {m_sdo[6:0], SDO};
            m_sdi = {m_sdi[6:0], SDI};
            m_bits++;
            if (m_bits == 8) begin
                m_bits = 0;
                if (m_byte == 0) begin
                    m_rnw = m_sdi[7];
                end else if (m_rnw && !m_skip) begin
                    if (exp_rd.size() == 0) begin
                        chk("rd_unexpected_byte", 32'd1, 32'd0);
                    end else begin
                        m_exp = exp_rd.pop_front();
                        chk("rd_byte", {24'h0, m_sdo}, {24'h0, m_exp});
                    end
                end
                m_byte++;
            end
        end
    end

    wr_t mw;
    always @(negedge Clk) begin
        if (nReset && Wr_Valid) begin
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", {26'h0, Wr_Address}, 32'hFFFF_FFFF);
            end else begin
                mw = exp_wr.pop_front();
                chk("wr_addr", {26'h0, Wr_Address}, {26'h0, mw.a});
                chk("wr_data", {24'h0, Wr_Data}, {24'h0, mw.d});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (3) @(negedge Clk);
        chk("rst_sdo",         {31'h0, SDO},          32'd1);
        chk("rst_wr_valid",    {31'h0, Wr_Valid},     32'd0);
        chk("rst_wr_addr",     {26'h0, Wr_Address},   32'd0);
        chk("rst_wr_data",     {24'h0, Wr_Data},      32'd0);
        chk("rst_data_format", {24'h0, Data_Format},  {24'h0, FMT_RST});
        nReset = 1'b1;
        repeat (5) @(negedge Clk);

        // Write DATA_FORMAT
        pay = '{8'h09};
        run_txn(8'h31);
        chk("fmt_written", {24'h0, Data_Format}, 32'h09);

        // ID read
        pay = '{8'h00};
        run_txn(8'h80);

        // Coherent burst: live X changes after the command byte
        X = 16'h1234; Y = 16'hFEDC; Z = 16'h0001;
        pay = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        cs_low();
        plan(8'hF2);
        send_bits(8'hF2, 8);
        X = 16'h5555;
        foreach (pay[i]) send_bits(pay[i], 8);
        cs_high();

        // Wrap with MB=1, hold with MB=0
        pay = '{8'hA5};
        run_txn(8'h3F);
        pay = '{8'h00, 8'h00};
        run_txn(8'hFF);
        pay = '{8'h00, 8'h00};
        run_txn(8'hBF);

        // Abort a write after 4 data bits, then read the target back
        cs_low();
        send_bits(8'h2D, 8);
        send_bits(8'hAB, 4);
        cs_high();
        pay = '{8'h00};
        run_txn(8'hAD);

        // Write to read-only ID register is dropped
        pay = '{8'h12};
        run_txn(8'h00);
        pay = '{8'h00};
        run_txn(8'h80);

        // Reset during byte 2 of a burst read starting at 0x30
        pay = '{8'h09};
        run_txn(8'h31);
        cs_low();
        exp_rd.push_back(model_rd(6'h30));
        send_bits(8'hF0, 8);
        send_bits(8'hFF, 8);
        send_bits(8'hFF, 3);
        @(negedge Clk);
        nReset = 1'b0;
        @(negedge Clk);
        chk("midrst_sdo",         {31'h0, SDO},         32'd1);
        chk("midrst_data_format", {24'h0, Data_Format}, {24'h0, FMT_RST});
        chk("midrst_wr_valid",    {31'h0, Wr_Valid},    32'd0);
        repeat (2) @(negedge Clk);
        nReset = 1'b1;
        model_reset();
        send_bits(8'hFF, 5);
        cs_high();
        X = 16'hBEEF;
        pay = '{8'h00, 8'h00, 8'h00};
        run_txn(8'hF1);

        // Randomised traffic
        for (int t = 0; t < 30; t++) begin
            X = 16'($urandom);
            Y = 16'($urandom);
            Z = 16'($urandom);
            pay = {};
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) pay.push_back(8'($urandom));
            run_txn(8'($urandom_range(0, 255)));
        end

        repeat (20) @(negedge Clk);
        chk("rd_queue_drained", exp_rd.size(), 32'd0);
        chk("wr_queue_drained", exp_wr.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_accel_responder.md
Name: spi_accel_responder

Overview:
SPI responder (slave) that models the 3-axis accelerometer register interface at the device end of the 4-wire bus. The FPGA-side SPI initiator and the bench talk to it exactly as they would to the physical part. It holds a 64 x 8 register file and serves sample registers 0x32–0x37 from fabric-supplied X/Y/Z words. It is used as an in-system loopback target and as the simulation model for initiator verification.

Parameters:
Device_ID, 8'hE5, read-only value of register 0x00
Format_Reset, 8'h00, reset value of register 0x31 (DATA_FORMAT)

Ports:
Clk  in  1  system clock; all logic on rising edge
nReset  in  1  asynchronous active-low reset
X  in  16  two's-complement X sample; served as 0x32 (LSB) and 0x33 (MSB)
Y  in  16  two's-complement Y sample; served as 0x34 and 0x35
Z  in  16  two's-complement Z sample; served as 0x36 and 0x37
nCS  in  1  SPI chip select, active low, asynchronous to Clk
SClk  in  1  SPI clock, mode 3 (idles high), asynchronous to Clk
SDI  in  1  serial data from the initiator, MSB first
SDO  out  1  serial data to the initiator, MSB first
Wr_Valid  out  1  one-Clk pulse per accepted register write
Wr_Address  out  6  address of the accepted write; valid with Wr_Valid
Wr_Data  out  8  data of the accepted write; valid with Wr_Valid
Data_Format  out  8  current contents of register 0x31

Behaviour:
- Reset (nReset low, asynchronous): SDO=1; Wr_Valid=0; Wr_Address=0; Wr_Data=0; Data_Format=Format_Reset; all registers 0x00 except 0x31; state Idle.
- Synchronisers: nCS, SClk and SDI each pass through 2 flip-flops. Edges are detected on the synchronised copies. Supported SClk half-period: 4 Clk cycles or more.
- Sampling and driving: SDI is sampled on each synchronised SClk rising edge. SDO is updated on each synchronised SClk falling edge. SDO reaches the pin exactly 3 Clk cycles after the SClk pin edge.
- States: Idle, Command, Data.
- Idle: SDO=1. On a synchronised nCS falling edge, snapshot X/Y/Z into the 0x32–0x37 shadow registers, clear the bit counter, and go to Command.
- Command: collect 8 bits in the form {R/nW, MB, A[5:0]}. On the 8th rising edge, latch the mode, MB and address, then go to Data. If reading, load the shift register with reg[A].
- Data, read: the MSB of the current byte is driven on the first falling edge of that byte, then one bit per falling edge. After the 8th rising edge of a byte: if MB=1, address <= address+1 modulo 64 (0x3F wraps to 0x00); if MB=0, the address holds. Reload the shift register from the new address.
- Data, write: after the 8th rising edge of a byte, if the address is writable, write reg[address]. Assert Wr_Valid for exactly 1 Clk with that address and data. Then apply the same MB address rule as reads.
- Read-only addresses: 0x00 and 0x32–0x37. Writes to them are dropped with no Wr_Valid, but the address still advances.
- Read sources: reads of 0x32–0x37 return the snapshot, never live inputs, so multi-byte samples stay coherent. Reads of 0x00 return Device_ID.
- Data_Format always mirrors reg 0x31.
- Abort: a synchronised nCS rising edge in any state returns to Idle within 1 Clk. A partial byte is discarded: no write, no Wr_Valid. SDO returns to 1.
- SClk edges while nCS is high are ignored.
- Asserting nReset mid-transaction forces all reset values immediately. The transaction in progress is lost, and the next nCS falling edge starts fresh.

Test Plan:
- Write 0x31: nCS low, send 0x31,0x09 in mode 3, half-period 5 Clk -> one Wr_Valid pulse with Wr_Address=0x31, Wr_Data=0x09; Data_Format=0x09 afterwards.
- ID read: send command 0x80 plus 8 dummy clocks -> the initiator shifts in 0xE5; no Wr_Valid.
- Coherent burst: X=0x1234, Y=0xFEDC, Z=0x0001; send command 0xF2 plus 48 clocks, and change X to 0x5555 after the command byte -> bytes 34 12 DC FE 01 00.
- Wrap and MB=0: write 0x3F=0xA5, then send MB read 0xFF for 2 bytes -> A5 E5. Send non-MB read 0xBF for 2 bytes -> A5 A5.
- Abort and read-only: send write 0x2D, then raise nCS after 4 data bits -> reg 0x2D stays 0x00, no Wr_Valid. Write 0x00=0x12 -> no Wr_Valid, ID still reads 0xE5.
- Reset mid-read: pulse nReset low during byte 2 of a burst -> SDO=1 and Data_Format=Format_Reset at once; the next transaction reads correctly.
